// File: rtl/collision_arbiter_pkg.sv
// Shared constants and helpers for the player/object collision arbiter.
// Object layer indices, default layer count and id-width sizing.
package collision_pkg;

    localparam int OBJ_BRACKET = 0;
    localparam int OBJ_NUMBER  = 1;
    localparam int OBJ_ROPE    = 2;
    localparam int OBJ_ENEMY   = 3;

    localparam int NUM_OBJ_DEFAULT = 4;
    localparam int CNT_W           = 8;

    // A single layer still needs a one-bit id on the event bus.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/collision_arbiter_if.sv
// Hit-event handshake between the arbiter and downstream scoring.
// master drives valid/id, slave drives ready.
interface collision_arbiter_if #(
    parameter int IDW = 2
);

    logic           event_valid;
    logic [IDW-1:0] event_id;
    logic           event_ready;

    modport master (
        output event_valid,
        output event_id,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_id,
        output event_ready
    );

endinterface

// File: rtl/collision_arbiter_event_fifo.sv
// Small synchronous FIFO for serialised hit events.
// A full FIFO accepts a push when it is popped in the same cycle.
module event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/collision_arbiter.sv
// Per-pixel player/object collision detection with per-frame debounced
// hit pulses and a serialised hit-event queue for scoring.
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int NUM_OBJ     = NUM_OBJ_DEFAULT,
    parameter int MIN_OVERLAP = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               drawing_request_player,
    input  logic [NUM_OBJ-1:0] drawing_request_obj,
    input  logic [NUM_OBJ-1:0] event_mask,
    output logic               collision,
    output logic [NUM_OBJ-1:0] obj_collision,
    output logic [NUM_OBJ-1:0] hit_pulse,
    output logic [NUM_OBJ-1:0] frame_hits,
    output logic               event_overflow,
    collision_arbiter_if.master ev
);

    localparam int IDW = id_width(NUM_OBJ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_OVERLAP - 1);

    logic [CNT_W-1:0]   cnt [NUM_OBJ];
    logic [NUM_OBJ-1:0] flag;
    logic [NUM_OBJ-1:0] hit_now;

    logic [NUM_OBJ-1:0] pend;
    logic [NUM_OBJ-1:0] pend_next;
    logic [NUM_OBJ-1:0] set_vec;
    logic [NUM_OBJ-1:0] drop_vec;
    logic [NUM_OBJ-1:0] low_vec;
    logic [NUM_OBJ-1:0] clr_vec;
    logic [IDW-1:0]     push_idx;
    logic               push_any;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [IDW-1:0]     fifo_head;

    assign obj_collision = drawing_request_obj &
                           {NUM_OBJ{drawing_request_player}};
    assign collision     = |obj_collision;

    // Threshold pixel: this overlap completes MIN_OVERLAP for the frame.
    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_now[i] = !startOfFrame && obj_collision[i] &&
                         !flag[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) cnt[i] <= '0;
            flag       <= '0;
            hit_pulse  <= '0;
            frame_hits <= '0;
        end else if (startOfFrame) begin
            for (int i = 0; i < NUM_OBJ; i++) cnt[i] <= '0;
            flag       <= '0;
            hit_pulse  <= '0;
            frame_hits <= flag;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (obj_collision[i] && !flag[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            flag      <= flag | hit_now;
            hit_pulse <= hit_now;
        end
    end

    assign fifo_pop = ev.event_valid && ev.event_ready;

    // Lowest pending index wins the single push slot each cycle.
    always_comb begin
        set_vec  = hit_pulse & event_mask;
        drop_vec = set_vec & pend;
        low_vec  = pend & (~pend + NUM_OBJ'(1));
        push_any = (|pend) && (!fifo_full || fifo_pop);
        clr_vec  = push_any ? low_vec : '0;
        push_idx = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (low_vec[i]) push_idx = push_idx | IDW'(i);
        end
        pend_next = (pend & ~clr_vec) | (set_vec & ~pend);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend           <= '0;
            event_overflow <= 1'b0;
        end else begin
            pend <= pend_next;
            if (|drop_vec) event_overflow <= 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (IDW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (push_any),
        .pop    (fifo_pop),
        .din    (push_idx),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .dout   (fifo_head)
    );

    assign ev.event_valid = !fifo_empty;
    assign ev.event_id    = fifo_head;

endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Parametrised per-pixel collision arbiter between the player sprite (the monkey) and NUM_OBJ object layers (brackets, numbers, ropes, enemies, …). Sits between the object drawing-request muxes and the score/game-state logic. Provides combinational per-object collision flags and debounced per-frame hit pulses that fire only once an overlap-pixel threshold is reached. Hit events are serialised through a small FIFO with a valid/ready handshake to downstream scoring.

## Interface
- NUM_OBJ, 4, number of object layers; ≥1
- MIN_OVERLAP, 4, overlapping pixels per frame needed to register a hit; 1..255
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at frame start
- drawing_request_player  in  1  player sprite pixel active
- drawing_request_obj  in  NUM_OBJ  per-object pixel active
- event_mask  in  NUM_OBJ  1 = object hits generate FIFO events
- event_ready  in  1  consumer accepts event this cycle
- collision  out  1  combinational: player && |drawing_request_obj
- obj_collision  out  NUM_OBJ  combinational: player && drawing_request_obj[i]
- hit_pulse  out  NUM_OBJ  registered, one cycle per object per frame at threshold
- frame_hits  out  NUM_OBJ  registered summary of previous frame's hits
- event_valid  out  1  FIFO non-empty
- event_id  out  $clog2(NUM_OBJ) (min 1)  object index at FIFO head
- event_overflow  out  1  sticky: an event was dropped

## Operation
- Per object i: overlap counter cnt[i] (8 bit, saturating at MIN_OVERLAP) and hit flag flag[i].
- startOfFrame cycle: cnt cleared, flag cleared, frame_hits <= flag (pre-clear value); the overlap on this cycle is not counted.
- Other cycles: if obj_collision[i] and !flag[i]: cnt[i]++; if cnt[i]==MIN_OVERLAP-1, then flag[i] <= 1 and hit_pulse[i] <= 1 on the next edge.
- hit_pulse defaults to 0 each cycle; at most one pulse per object per frame regardless of further overlap.
- Pending vector pend[NUM_OBJ]: set by hit_pulse[i] && event_mask[i]. If pend[i] is already set at that time, the event is dropped and event_overflow <= 1.
- Each cycle the lowest-index set pend bit is pushed into the FIFO if the FIFO is not full (or is popped the same cycle); that bit is cleared. One push per cycle.
- Pop when event_valid && event_ready. A full FIFO with simultaneous pop accepts a push.
- pend and the FIFO are not cleared at startOfFrame; events persist across frames.
- event_overflow is cleared only by reset.

## Timing
- Reset: hit_pulse, frame_hits, event_valid, event_overflow, pend, cnt, flag, and FIFO pointers = 0; event_id = 0.
- Threshold reached on pixel cycle T: hit_pulse high at T+1 only.
- Empty FIFO, no other pending: pend set at T+2 edge, pushed at T+3 edge, event_valid at T+3.
- Simultaneous hits: drained lowest index first, one per cycle.
- event_id/event_valid are stable while event_valid && !event_ready.
- MIN_OVERLAP=1: the first overlapping pixel produces the pulse next cycle.
- Asynchronous reset mid-frame or mid-handshake: everything returns to reset values immediately; in-flight events are lost.

## Structure
- Package collision_pkg: object index constants OBJ_BRACKET=0, OBJ_NUMBER=1, OBJ_ROPE=2, OBJ_ENEMY=3; default NUM_OBJ; id-width function.
- Sub-module event_fifo: synchronous FIFO parameterised by WIDTH and DEPTH, with push, pop, full, empty, and head data. Used here with WIDTH = id width.

## Test plan
- Reset asserted mid-frame with events queued -> all outputs 0 next cycle; event_valid 0 until a new hit.
- MIN_OVERLAP=4; 3 overlap pixels with obj1 in a frame -> no hit_pulse. Next frame, 4 pixels -> hit_pulse=0010 for one cycle, then event_id=1 with event_valid, popped with ready=1.
- 100 overlap pixels with obj2 across one frame -> exactly one hit_pulse. After the next startOfFrame, frame_hits=0100. Second frame repeats -> second pulse.
- obj0 and obj3 reach threshold on the same cycle, ready=1 -> hit_pulse=1001. Events appear as id 0 then id 3 on consecutive cycles.
- ready=0, FIFO_DEPTH=4; hits on obj0..3 then obj0 again in a later frame -> FIFO holds 0,1,2,3 and pend[0] is set. A further obj0 hit -> event_overflow=1. Releasing ready drains 0,1,2,3,0.
- event_mask=0111; obj3 hit -> hit_pulse[3] fires, no event pushed, event_valid stays 0.
